// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and flag construction for the
// pipelined ALU and its combinational core.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MAX  = 3'd2;
    localparam logic [2:0] OP_MIN  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_ORR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam int FLG_NEG  = 3;
    localparam int FLG_POS  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_OVF  = 0;

    // Flags of a zero result with no overflow.
    localparam logic [3:0] FLAG_RESET = 4'b0010;

    function automatic logic [3:0] make_flag(input logic neg, input logic zero, input logic ovf);
        logic [3:0] f;
        f            = '0;
        f[FLG_NEG]   = neg;
        f[FLG_POS]   = !neg && !zero;
        f[FLG_ZERO]  = zero;
        f[FLG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational signed ALU: 8 operations, raw overflow detection, optional
// ADD/SUB saturation, and {NEG,POS,ZERO,OVF} flags of the final result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic        [2:0]       i_oper,
    input  logic                    i_sat,
    output logic signed [WIDTH-1:0] o_result,
    output logic        [3:0]       o_flag
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;
    logic signed [WIDTH-1:0] w_raw;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic                    w_ovf;

    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_a_neg = i_a[WIDTH-1];
    assign w_b_neg = i_b[WIDTH-1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_raw = w_sum;
        w_ovf = 1'b0;
        case (i_oper)
            OP_ADD: begin
                w_raw = w_sum;
                w_ovf = (w_a_neg == w_b_neg) && (w_sum[WIDTH-1] != w_a_neg);
            end
            OP_SUB: begin
                w_raw = w_diff;
                w_ovf = (w_a_neg != w_b_neg) && (w_diff[WIDTH-1] != w_a_neg);
            end
            OP_MAX:  w_raw = (i_a >= i_b) ? i_a : i_b;
            OP_MIN:  w_raw = (i_a <= i_b) ? i_a : i_b;
            OP_AND:  w_raw = i_a & i_b;
            OP_ORR:  w_raw = i_a | i_b;
            OP_XOR:  w_raw = i_a ^ i_b;
            OP_XNOR: w_raw = ~(i_a ^ i_b);
            default: w_raw = w_sum;
        endcase
    end

    // Overflow is only ever raised by ADD/SUB, so it alone gates saturation.
    assign w_res    = (i_sat && w_ovf) ? (w_a_neg ? SAT_MIN : SAT_MAX) : w_raw;
    assign o_result = w_res;
    assign o_flag   = make_flag(w_res[WIDTH-1], w_res == '0, w_ovf);

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake and full backpressure: optional
// operand register stage, output register stage, and a sticky overflow bit.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter bit REG_IN = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [WIDTH-1:0] i_data,
    input  logic signed [WIDTH-1:0] i_arg0,
    input  logic signed [WIDTH-1:0] i_arg1,
    input  logic        [2:0]       i_oper,
    input  logic                    i_imm,
    input  logic                    i_sat,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o_result,
    output logic        [3:0]       o_flag,
    input  logic                    i_clr_sticky,
    output logic                    o_sticky_ovf
);

    logic signed [WIDTH-1:0] w_a_in;
    logic signed [WIDTH-1:0] w_s1_a;
    logic signed [WIDTH-1:0] w_s1_b;
    logic        [2:0]       w_s1_oper;
    logic                    w_s1_sat;
    logic                    w_s1_valid;
    logic signed [WIDTH-1:0] w_core_result;
    logic        [3:0]       w_core_flag;
    logic                    w_s2_adv;

    logic                    r_o_valid;
    logic signed [WIDTH-1:0] r_result;
    logic        [3:0]       r_flag;
    logic                    r_sticky;

    assign w_a_in   = i_imm ? i_data : i_arg0;
    assign w_s2_adv = !r_o_valid || i_ready;

    generate
        if (REG_IN) begin : g_reg_in
            logic                    r_s1_valid;
            logic signed [WIDTH-1:0] r_s1_a;
            logic signed [WIDTH-1:0] r_s1_b;
            logic        [2:0]       r_s1_oper;
            logic                    r_s1_sat;
            logic                    w_s1_adv;

            assign w_s1_adv = !r_s1_valid || w_s2_adv;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s1_valid <= 1'b0;
                end else if (w_s1_adv) begin
                    r_s1_valid <= i_valid;
                end
            end

            // NOTE: the operand payload has no reset; r_s1_valid alone decides whether it is meaningful.
            always_ff @(posedge i_clk) begin
                if (w_s1_adv && i_valid) begin
                    r_s1_a    <= w_a_in;
                    r_s1_b    <= i_arg1;
                    r_s1_oper <= i_oper;
                    r_s1_sat  <= i_sat;
                end
            end

            assign o_ready    = w_s1_adv;
            assign w_s1_valid = r_s1_valid;
            assign w_s1_a     = r_s1_a;
            assign w_s1_b     = r_s1_b;
            assign w_s1_oper  = r_s1_oper;
            assign w_s1_sat   = r_s1_sat;
        end else begin : g_no_reg_in
            assign o_ready    = w_s2_adv;
            assign w_s1_valid = i_valid;
            assign w_s1_a     = w_a_in;
            assign w_s1_b     = i_arg1;
            assign w_s1_oper  = i_oper;
            assign w_s1_sat   = i_sat;
        end
    endgenerate

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (w_s1_a),
        .i_b      (w_s1_b),
        .i_oper   (w_s1_oper),
        .i_sat    (w_s1_sat),
        .o_result (w_core_result),
        .o_flag   (w_core_flag)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o_valid <= 1'b0;
            r_result  <= '0;
            r_flag    <= FLAG_RESET;
        end else if (w_s2_adv) begin
            // NOTE: non-blocking updates so every register samples values from before the edge.
            r_o_valid <= w_s1_valid;
            if (w_s1_valid) begin
                r_result <= w_core_result;
                r_flag   <= w_core_flag;
            end
        end
    end

    // A set on an accepted overflow output takes priority over a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_o_valid && i_ready && r_flag[FLG_OVF]) begin
            r_sticky <= 1'b1;
        end else if (i_clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_valid      = r_o_valid;
    assign o_result     = r_result;
    assign o_flag       = r_flag;
    assign o_sticky_ovf = r_sticky;

endmodule
